// File: rtl/fft_unload.sv
// -----------------------------------------------------------------------------
// fft_unload
//   Drain side of the FFT core. A one-cycle fft_done pulse captures the whole
//   parallel result bus into a holding register, which frees the core to start
//   its next frame. The captured bins are then streamed out one per transfer
//   over a valid/ready interface, bin 0 first, with out_last on the final bin.
//   An fft_done that arrives while a frame is still streaming is dropped and
//   counted in a saturating counter.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset, overrides every other input
//   fft_done    one-cycle capture strobe, fft_res valid in the same cycle
//   fft_res     NBINS signed bins, bin k = fft_res[k*BIN_W +: BIN_W]
//   out_valid   out_data / out_idx / out_last are valid
//   out_ready   consumer accepts when out_valid && out_ready
//   out_data    current bin, signed, passed through unmodified
//   out_idx     index of the current bin, 0..NBINS-1
//   out_last    high with out_valid on bin NBINS-1
//   busy        high from capture until the last bin is accepted
//   frame_done  one-cycle pulse on the cycle after the last bin is accepted
//   drop_cnt    saturating count of frames dropped while streaming
// -----------------------------------------------------------------------------
module fft_unload #(
  parameter int NBINS = 51,
  parameter int BIN_W = 16,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_done,
  input  logic [NBINS*BIN_W-1:0]   fft_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [BIN_W-1:0]  out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

  state_t                      state;
  logic [NBINS-1:0][BIN_W-1:0] hold;
  logic [NBINS-1:0][BIN_W-1:0] res_bins;
  logic [IDX_W-1:0]            next_idx;
  logic                        capture;
  logic                        drop;

  // Same bit layout as fft_res; viewing it as a packed array of bins makes
  // the per-bin selects readable.
  assign res_bins = fft_res;
  assign next_idx = out_idx + 1'b1;

  // A new frame is accepted whenever nothing is streaming (IDLE or DONE);
  // during SEND the holding register is in use, so the strobe is a drop.
  assign capture  = fft_done && (state != SEND);
  assign drop     = fft_done && (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // NOTE: the holding register is wide but has a defined reset value, so
      // it is cleared here along with the control state rather than left to
      // power-up contents.
      hold       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      // NOTE: all state in this block uses non-blocking assignments, so every
      // right-hand side sees the value from before this edge.
      frame_done <= 1'b0;

      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      unique case (state)
        IDLE, DONE: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          if (capture) begin
            // Bin 0 comes straight from the bus: the holding register only
            // becomes readable after this edge.
            hold      <= res_bins;
            out_data  <= res_bins[0];
            out_idx   <= '0;
            out_last  <= (NBINS == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end else begin
            state     <= IDLE;
          end
        end

        SEND: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              // Advance on the accepting edge itself so a held-high ready
              // yields one bin per cycle with no bubble.
              out_idx    <= next_idx;
              out_data   <= hold[next_idx];
              out_last   <= (next_idx == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_unload.sv
// -----------------------------------------------------------------------------
// tb_fft_unload
//   Directed bench for fft_unload: single frame, backpressure, overrun drop,
//   back-to-back capture from DONE, mid-frame reset, drop on the last-beat
//   cycle and drop counter saturation. Inputs change 1 ns after the rising
//   edge; outputs are sampled at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_fft_unload;

  localparam int NBINS = 51;
  localparam int BIN_W = 16;
  localparam int IDX_W = 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     fft_done = 1'b0;
  logic                     out_ready = 1'b0;
  logic [NBINS*BIN_W-1:0]   fft_res = '0;
  logic                     out_valid;
  logic signed [BIN_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;
  logic                     frame_done;
  logic [7:0]               drop_cnt;

  int exp_bins [NBINS];
  int errors = 0;
  int checks = 0;

  fft_unload #(
    .NBINS (NBINS),
    .BIN_W (BIN_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fft_done   (fft_done),
    .fft_res    (fft_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: bin k = k*257-6000 ; kind 1: every bin = -32768
  task automatic load_frame(input int kind);
    for (int k = 0; k < NBINS; k++) begin
      exp_bins[k] = (kind == 0) ? (k * 257 - 6000) : -32768;
      fft_res[k*BIN_W +: BIN_W] = BIN_W'(exp_bins[k]);
    end
  endtask

  task automatic capture(input int kind);
    load_frame(kind);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("cap_valid", int'(out_valid), 1);
    check("cap_idx",   int'(out_idx),   0);
    check("cap_data",  int'(out_data),  exp_bins[0]);
    check("cap_busy",  int'(busy),      1);
    check("cap_last",  int'(out_last),  0);
  endtask

  // mode 0: ready held high ; mode 1: pseudo-random ready.
  // drop_at: beat index at which a second fft_done (all 7FFF) is pulsed.
  // stop_at: return as soon as this beat is presented, without accepting it.
  task automatic drain(input int mode, input int drop_at, input int stop_at,
                       output int cycles);
    int  beats;
    bit  dropped;
    beats   = 0;
    cycles  = 0;
    dropped = 1'b0;
    while (beats < NBINS && beats != stop_at) begin
      if (cycles >= 2000) begin
        check("drain_timeout", cycles, -1);
        return;
      end
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      check("beat_valid", int'(out_valid),  1);
      check("beat_idx",   int'(out_idx),    beats);
      check("beat_data",  int'(out_data),   exp_bins[beats]);
      check("beat_last",  int'(out_last),   int'(beats == NBINS - 1));
      check("beat_fdone", int'(frame_done), 0);
      if (beats == drop_at && !dropped) begin
        dropped  = 1'b1;
        fft_res  = {NBINS{16'h7FFF}};
        fft_done = 1'b1;
      end
      tick();
      fft_done = 1'b0;
      cycles++;
      if (out_ready) beats++;
    end
    if (beats == NBINS) begin
      check("done_valid", int'(out_valid),  0);
      check("done_fdone", int'(frame_done), 1);
      check("done_busy",  int'(busy),       0);
      check("done_last",  int'(out_last),   0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(out_valid),  0);
    check("rst_data",  int'(out_data),   0);
    check("rst_idx",   int'(out_idx),    0);
    check("rst_last",  int'(out_last),   0);
    check("rst_busy",  int'(busy),       0);
    check("rst_fdone", int'(frame_done), 0);
    check("rst_drop",  int'(drop_cnt),   0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_valid", int'(out_valid), 0);

    // Single frame, ready held high: 51 beats in 51 cycles
    out_ready = 1'b1;
    capture(0);
    drain(0, -1, -1, cyc);
    check("t1_cycles", cyc, NBINS);
    tick();
    check("t1_fdone_pulse", int'(frame_done), 0);
    check("t1_idle_valid",  int'(out_valid),  0);
    check("t1_idle_busy",   int'(busy),       0);

    // Backpressure
    capture(0);
    drain(1, -1, -1, cyc);
    check("t2_drop", int'(drop_cnt), 0);
    tick();

    // Overrun at out_idx 20: stream keeps first-frame values
    out_ready = 1'b1;
    capture(0);
    drain(0, 20, -1, cyc);
    check("t3_drop", int'(drop_cnt), 1);

    // Back-to-back: capture in the DONE cycle
    load_frame(1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("t4_valid", int'(out_valid), 1);
    check("t4_data",  int'(out_data),  -32768);
    check("t4_idx",   int'(out_idx),   0);
    check("t4_drop",  int'(drop_cnt),  1);
    drain(0, -1, -1, cyc);
    tick();
    check("t4_idle_valid", int'(out_valid), 0);

    // Reset at out_idx 30
    capture(0);
    drain(0, -1, 30, cyc);
    check("t5_pre_idx", int'(out_idx), 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", int'(out_valid),  0);
    check("t5_busy",  int'(busy),       0);
    check("t5_idx",   int'(out_idx),    0);
    check("t5_drop",  int'(drop_cnt),   0);
    check("t5_fdone", int'(frame_done), 0);
    tick();
    check("t5_fdone2", int'(frame_done), 0);
    check("t5_valid2", int'(out_valid),  0);

    // Fresh frame after reset; fft_done on the last-beat cycle is a drop
    capture(0);
    drain(0, NBINS - 1, -1, cyc);
    check("t5_simul_drop", int'(drop_cnt), 1);
    tick();
    check("t5_no_second", int'(out_valid), 0);
    check("t5_idle_busy", int'(busy),      0);

    // Saturation: 300 drops while stalled in SEND
    capture(0);
    out_ready = 1'b0;
    repeat (300) begin
      fft_done = 1'b1;
      tick();
    end
    fft_done = 1'b0;
    check("t6_drop",       int'(drop_cnt), 255);
    check("t6_hold_valid", int'(out_valid), 1);
    check("t6_hold_idx",   int'(out_idx),   0);
    check("t6_hold_data",  int'(out_data),  exp_bins[0]);
    tick();
    check("t6_drop_hold",  int'(drop_cnt), 255);
    drain(0, -1, -1, cyc);
    check("t6_drop_end",   int'(drop_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_unload.md
Name: fft_unload

Overview:
- Drain side of the 128-point FFT core.
- On each fft_done pulse it latches the full parallel result bus fft_res (NBINS signed bins of BIN_W bits) into a holding register.
- It then streams the bins out one per transfer over a valid/ready interface, bin 0 first, marking the final bin with out_last.
- It sits between the FFT core and downstream consumers (UART/DMA packer), so the core can start its next frame as soon as the capture is done.

Parameters:
- NBINS, 51, number of result bins on fft_res.
- BIN_W, 16, width of one signed bin; fft_res width is NBINS*BIN_W (816 at defaults).
- IDX_W, 6, width of out_idx; must satisfy 2**IDX_W >= NBINS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fft_done  in  1  one-cycle pulse from the FFT core; fft_res is valid in the same cycle.
- fft_res  in  NBINS*BIN_W  parallel result; bin k = fft_res[k*BIN_W +: BIN_W], signed.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  BIN_W  current bin, signed.
- out_idx  out  IDX_W  index of current bin, 0..NBINS-1.
- out_last  out  1  high with out_valid when out_idx == NBINS-1.
- busy  out  1  high from capture until the last bin is accepted.
- frame_done  out  1  one-cycle pulse on the cycle after the last bin is accepted.
- drop_cnt  out  8  saturating count of frames dropped because busy was high.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, frame_done=0, drop_cnt=0.
  - Holding register cleared.
  - rst takes priority over every other input in the same cycle.
  - Reset mid-frame abandons the frame: no frame_done and no further beats.
- States:
  - IDLE:
    - busy=0, out_valid=0.
    - fft_done=1 at edge N: latch all of fft_res, out_idx<=0, go to SEND.
    - At edge N: busy=1, out_valid=1, out_data=bin0.
    - Capture-to-first-valid latency is 1 cycle.
  - SEND:
    - out_valid=1 continuously.
    - On a transfer (out_valid && out_ready) with out_idx<NBINS-1: out_idx<=out_idx+1, out_data<=next bin, on the same edge.
    - No bubble: back-to-back transfers give one bin per cycle when out_ready stays high.
    - Without out_ready, out_data, out_idx and out_last hold stable. Data must not change while valid and not accepted.
    - On a transfer with out_idx==NBINS-1: go to DONE, out_valid<=0.
  - DONE:
    - One cycle: frame_done=1, busy=0.
    - Next state is IDLE, unless fft_done=1 in this cycle, in which case it captures and enters SEND exactly as IDLE does.
- out_last is a registered compare (out_idx==NBINS-1) qualified by out_valid.
- Drops:
  - fft_done while state==SEND is ignored; the holding register is not overwritten.
  - drop_cnt increments by 1 and saturates at 255.
- Simultaneous events:
  - fft_done in the same cycle as acceptance of the last bin counts as a drop, because state is still SEND.
  - fft_done in DONE or IDLE is captured.
- Width: bins pass through unmodified. No rounding, scaling or sign change.
- The holding register is loaded only on capture.

Test Plan:
- Single frame, out_ready=1 (defaults): fft_res with bin k = k*257-6000, pulse fft_done at cycle 10.
  - out_valid rises at cycle 11 with out_data=-6000, out_idx=0.
  - 51 consecutive beats, last beat out_data=6850, out_idx=50, out_last=1.
  - frame_done pulses at cycle 62; busy low from cycle 62.
- Backpressure: out_ready toggled 1,0,0,1,… pseudo-randomly.
  - Received sequence is identical to the first test.
  - out_data and out_idx stable across every stalled cycle.
  - Exactly 51 accepted beats.
- Overrun: second fft_done at out_idx=20 with all bins=16'h7FFF.
  - Stream continues with the first frame's values.
  - drop_cnt=1; no second frame is emitted.
- Back-to-back: fft_done asserted in the DONE cycle with bins=16'h8000.
  - Second frame starts the next cycle: out_data=-32768, out_idx=0.
  - drop_cnt unchanged.
- Reset mid-frame: rst=1 for one cycle at out_idx=30.
  - Next cycle: out_valid=0, busy=0, out_idx=0, drop_cnt=0.
  - No frame_done.
  - A subsequent fft_done streams normally from bin 0.
- Saturation: 300 fft_done pulses while in SEND with out_ready=0.
  - drop_cnt=255 and holds.
